fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side drain engine for the fifo1 read port. It pops words from the show-ahead FIFO interface (rdata, rempty, rinc) and presents them as a valid/ready stream master with packet framing (m_tlast every PKT_LEN words).
- A 2-entry output skid buffer decouples m_tready from rinc, so there is no combinational ready-to-pop path.
- It sits between fifo1 and any downstream stream consumer; it is the reader counterpart to the word producer that feeds the FIFO write side.

Parameters:
- DSIZE, 8: data width; must match fifo1 DSIZE.
- PKT_LEN, 4: words per packet; m_tlast is set on the last word. Range 1..2^16-1.
- CNT_W, 16: width of the words_out counter.

Ports:
- aclk  in  1  single clock for the whole block; also drives the fifo1 rclk.
- aresetn  in  1  asynchronous active-low reset.
- enable  in  1  allows new pops from the FIFO; buffered words drain regardless.
- rdata  in  DSIZE  FIFO head word; valid whenever rempty=0 (show-ahead).
- rempty  in  1  FIFO empty flag.
- rinc  out  1  pop strobe; the FIFO advances on the aclk edge where rinc=1.
- m_tdata  out  DSIZE  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  last word of a packet.
- words_out  out  CNT_W  count of completed stream handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (aresetn=0, asynchronous):
  - m_tvalid=0, m_tdata=0, m_tlast=0, words_out=0.
  - Buffer state EMPTY; packet counter pkt_cnt=0.
  - rinc is forced to 0 while aresetn=0.
  - Reset mid-operation discards buffered words. Words already popped from the FIFO are lost by design.
- Buffer state machine, on registered occupancy:
  - States: EMPTY(0), ONE(1), TWO(2).
  - pop = rinc; push_out = m_tvalid && m_tready.
  - EMPTY -> ONE on pop.
  - ONE -> TWO on pop && !push_out; ONE -> EMPTY on push_out && !pop; ONE stays on pop && push_out.
  - TWO -> ONE on push_out. No pop is possible in TWO.
- rinc = aresetn && enable && !rempty && (state != TWO). rinc is a function of registered state and FIFO/enable inputs only; m_tready never reaches rinc.
- Capture: on a pop edge, rdata is written into the buffer together with tag last = (pkt_cnt == PKT_LEN-1).
  - pkt_cnt increments on each pop and wraps to 0 after PKT_LEN-1.
- Latency: a word popped at edge N is on m_tdata with m_tvalid=1 from edge N through at least edge N+1 (one-cycle latency).
- Throughput: one word per cycle sustained when m_tready=1 and the FIFO is non-empty.
- Output registers: m_tdata and m_tlast come from the head entry; m_tvalid = (state != EMPTY).
  - While m_tvalid && !m_tready, m_tdata and m_tlast hold stable.
  - m_tvalid never drops without a handshake, except on reset.
- Order is strict FIFO order: no loss, no duplication.
- words_out increments on each handshake and wraps with no saturation.
- enable=0:
  - rinc=0; buffered words still drain.
  - pkt_cnt is retained, so packet boundaries continue across enable gaps.
- rempty=1 with the buffer non-empty: drain continues; m_tvalid drops after the last handshake.
- PKT_LEN=1: every word carries m_tlast=1.

Test Plan:
1. PKT_LEN=4, FIFO preloaded with 0x01..0x08, m_tready=1, enable=1 -> rinc high 8 cycles; output 0x01..0x08 one per cycle, first valid one cycle after first pop; m_tlast only on 0x04 and 0x08; words_out=8.
2. FIFO holds 0xA0..0xA5, m_tready=0 -> exactly 2 pops then rinc=0; m_tdata=0xA0 held stable with m_tvalid=1; then m_tready=1 -> 0xA0..0xA5 in order, m_tlast on 0xA3, words_out=6.
3. 10 words 0x10..0x19, m_tready toggling 1,0,1,0 -> order preserved, m_tlast on 0x13 and 0x17, no duplicates, words_out=10.
4. enable=0 after 3 pops of 0x31..0x36 -> no further rinc; 0x31..0x33 delivered, none with m_tlast; enable=1 -> 0x34 carries m_tlast.
5. aresetn pulsed low mid-packet with 2 words buffered and m_tready=0 -> m_tvalid=0 and words_out=0 immediately; after release, the next popped word starts a new packet (m_tlast on its 4th word).
6. FIFO writer adds one word every 3 cycles (rempty toggling), m_tready=1 -> m_tvalid pulses once per word, no duplication, words_out equals words written.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a show-ahead FIFO read port into a valid/ready
// stream master. Words pass through a 2-entry skid buffer, so m_tready has no
// combinational path to rinc. The buffer also adds packet framing: m_tlast is
// set on every PKT_LEN-th word, and words_out counts completed handshakes.
module fifo_stream_reader #(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DSIZE-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [CNT_W-1:0] words_out
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  state_t           r_state;
  logic             r_valid;
  logic [DSIZE-1:0] r_head_data;
  logic             r_head_last;
  logic [DSIZE-1:0] r_tail_data;
  logic             r_tail_last;
  logic [15:0]      r_pkt_cnt;
  logic [CNT_W-1:0] r_words;

  logic             w_pop;
  logic             w_push;
  logic             w_last_tag;

  // The pop decision depends only on registered occupancy and the FIFO/enable
  // inputs. A full buffer blocks the pop, so the skid never overflows.
  assign rinc       = aresetn && enable && !rempty && (r_state != S_TWO);
  assign w_pop      = rinc;
  assign w_push     = r_valid && m_tready;
  assign w_last_tag = (r_pkt_cnt == LAST_IDX);

  assign m_tvalid   = r_valid;
  assign m_tdata    = r_head_data;
  assign m_tlast    = r_head_last;
  assign words_out  = r_words;

  // Skid buffer occupancy FSM. The head entry always drives the stream outputs.
  // The tail entry holds the word that was popped while the head was stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_EMPTY;
      r_valid     <= 1'b0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_pop) begin
            r_head_data <= rdata;
            r_head_last <= w_last_tag;
            r_valid     <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_pop && !w_push) begin
            r_tail_data <= rdata;
            r_tail_last <= w_last_tag;
            r_state     <= S_TWO;
          end else if (w_pop && w_push) begin
            // The head is consumed and replaced in the same cycle.
            r_head_data <= rdata;
            r_head_last <= w_last_tag;
          end else if (w_push) begin
            r_valid     <= 1'b0;
            r_state     <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_push) begin
            r_head_data <= r_tail_data;
            r_head_last <= r_tail_last;
            r_state     <= S_ONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  // The packet position advances on every pop, and enable gaps keep it, so
  // framing continues across pauses in the input.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pkt_cnt <= '0;
    end else if (w_pop) begin
      if (w_last_tag) begin
        r_pkt_cnt <= '0;
      end else begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
    end
  end

  // Handshake counter. It wraps naturally at 2^CNT_W.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_words <= '0;
    end else if (w_push) begin
      r_words <= r_words + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader. A queue-based show-ahead FIFO model feeds
// the DUT. Stimulus pushes hand-specified expected words into a scoreboard
// queue, and a negedge monitor pops and compares on every handshake.
module tb_fifo_stream_reader;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic        rempty = 1'b1;
  logic        m_tready = 1'b0;
  logic        rinc;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic [15:0] words_out;

  logic [7:0]  fifo_q[$];
  logic [8:0]  exp_q[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          pops = 0;
  int          vld_rises = 0;
  logic        pop_pend = 1'b0;
  logic        prev_vld = 1'b0;
  logic        stall_seen = 1'b0;
  logic [8:0]  stall_word = '0;

  fifo_stream_reader #(.DSIZE(8), .PKT_LEN(4), .CNT_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .rdata(rdata),
    .rempty(rempty), .rinc(rinc), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .words_out(words_out)
  );

  always #5 aclk = ~aclk;

  function automatic void refresh();
    if (fifo_q.size() > 0) begin
      rempty = 1'b0;
      rdata  = fifo_q[0];
    end else begin
      rempty = 1'b1;
      rdata  = 8'h00;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // FIFO model: the head advances on an edge where rinc was high
  always @(negedge aclk) pop_pend <= rinc;

  always @(posedge aclk) begin
    logic [7:0] tmp;
    #1;
    if (pop_pend && fifo_q.size() > 0) begin
      tmp = fifo_q.pop_front();
      pops++;
    end
    refresh();
  end

  // Monitor: handshake scoreboard, hold-stability and valid-pulse counting
  always @(negedge aclk) begin
    logic [8:0] e;
    if (!aresetn) begin
      stall_seen = 1'b0;
      prev_vld   = 1'b0;
    end else begin
      if (stall_seen) begin
        chk("hold_valid", 32'(m_tvalid), 32'd1);
        chk("hold_word", 32'({m_tlast, m_tdata}), 32'(stall_word));
      end
      if (m_tvalid && !prev_vld) vld_rises++;
      prev_vld = m_tvalid;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_bad++;
          $display("FAIL stream_extra: got word %0h expected none", {m_tlast, m_tdata});
        end else begin
          e = exp_q.pop_front();
          chk("stream_word{last,data}", 32'({m_tlast, m_tdata}), 32'(e));
        end
        stall_seen = 1'b0;
      end else if (m_tvalid) begin
        stall_seen = 1'b1;
        stall_word = {m_tlast, m_tdata};
      end else begin
        stall_seen = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic load(input logic [7:0] d);
    fifo_q.push_back(d);
    refresh();
  endtask

  task automatic expect_w(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    enable   = 1'b0;
    m_tready = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    refresh();
    cyc(2);
    aresetn = 1'b1;
    cyc(1);
  endtask

  task automatic drain(input int limit, input int exp_words, input bit toggle);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || m_tvalid) && k < limit) begin
      cyc(1);
      if (toggle) m_tready = ~m_tready;
      k++;
    end
    if (k >= limit) begin
      n_chk++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    chk("words_out", 32'(words_out), 32'(exp_words));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(1);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_words", 32'(words_out), 32'd0);
    chk("rst_rinc", 32'(rinc), 32'd0);

    // 1: preloaded burst, full throughput, tlast on 04 and 08
    do_reset();
    m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      load(8'(i));
      expect_w(8'(i), (i == 4) || (i == 8));
    end
    pops = 0;
    enable = 1'b1;
    @(negedge aclk);
    chk("t1_first_rinc", 32'(rinc), 32'd1);
    chk("t1_no_valid_yet", 32'(m_tvalid), 32'd0);
    @(negedge aclk);
    chk("t1_first_valid", 32'(m_tvalid), 32'd1);
    chk("t1_first_data", 32'(m_tdata), 32'h01);
    cyc(7);
    chk("t1_pops_back_to_back", 32'(pops), 32'd8);
    drain(50, 8, 1'b0);

    // 2: stalled sink, exactly two pops then hold
    do_reset();
    for (int i = 0; i < 6; i++) begin
      load(8'hA0 + 8'(i));
      expect_w(8'hA0 + 8'(i), i == 3);
    end
    enable = 1'b1;
    cyc(6);
    chk("t2_two_pops", 32'(fifo_q.size()), 32'd4);
    chk("t2_rinc_blocked", 32'(rinc), 32'd0);
    chk("t2_valid_held", 32'(m_tvalid), 32'd1);
    chk("t2_data_held", 32'(m_tdata), 32'hA0);
    m_tready = 1'b1;
    drain(50, 6, 1'b0);

    // 3: toggling ready, order and framing preserved
    do_reset();
    for (int i = 0; i < 10; i++) begin
      load(8'h10 + 8'(i));
      expect_w(8'h10 + 8'(i), (i == 3) || (i == 7));
    end
    enable = 1'b1;
    m_tready = 1'b1;
    drain(200, 10, 1'b1);

    // 4: enable gap after three pops keeps the packet position
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load(8'h31 + 8'(i));
      expect_w(8'h31 + 8'(i), i == 3);
    end
    pops = 0;
    enable = 1'b1;
    cyc(3);
    enable = 1'b0;
    chk("t4_three_pops", 32'(pops), 32'd3);
    cyc(5);
    chk("t4_no_pop_disabled", 32'(fifo_q.size()), 32'd3);
    chk("t4_three_delivered", 32'(words_out), 32'd3);
    enable = 1'b1;
    drain(50, 6, 1'b0);

    // 5: reset mid-packet with two words buffered; 0x50/0x51 are lost
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) load(8'h50 + 8'(i));
    cyc(4);
    chk("t5_buffered_two", 32'(fifo_q.size()), 32'd4);
    aresetn = 1'b0;
    #1;
    chk("t5_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("t5_rst_words", 32'(words_out), 32'd0);
    chk("t5_rst_rinc", 32'(rinc), 32'd0);
    chk("t5_rst_tdata", 32'(m_tdata), 32'd0);
    for (int i = 2; i < 6; i++) expect_w(8'h50 + 8'(i), i == 5);
    cyc(1);
    aresetn = 1'b1;
    m_tready = 1'b1;
    drain(50, 4, 1'b0);

    // 6: trickle writer, one word every three cycles
    do_reset();
    m_tready = 1'b1;
    enable = 1'b1;
    vld_rises = 0;
    for (int i = 0; i < 6; i++) begin
      load(8'h60 + 8'(i));
      expect_w(8'h60 + 8'(i), i == 3);
      cyc(3);
    end
    drain(50, 6, 1'b0);
    chk("t6_valid_pulses", 32'(vld_rises), 32'd6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
